genius_seq_player: RTL and testbench

- Sequencer that owns the Genius colour sequence and plays it back through the two shared timers (timer 1 = lamp-on time, timer 2 = inter-lamp gap) using START_x/END_x handshakes.
- Sits between the genius game FSM, which issues PLAY/EXTEND/CLEAR, and the timers plus the VGA/LED colour path.
- Stores up to MAX_LEN 2-bit colour indices.
- Exposes a read port so the game FSM can compare player input against the stored sequence.

---
 rtl/genius_pkg.sv | 37 +++
 rtl/genius_lfsr16.sv | 21 ++
 rtl/genius_seq_player.sv | 156 +++++++++++++++
 tb/tb_genius_seq_player.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// Shared definitions for the Genius sequence player: lamp codes,
// colour index type, LFSR mask, FSM states and the index->code map.
package genius_pkg;

    localparam logic [2:0] C_OFF  = 3'd0;
    localparam logic [2:0] GREEN  = 3'd2;
    localparam logic [2:0] RED    = 3'd3;
    localparam logic [2:0] BLUE   = 3'd4;
    localparam logic [2:0] YELLOW = 3'd6;
    localparam logic [2:0] POWER  = 3'd7;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef logic [1:0] cidx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON_START,
        S_ON_WAIT,
        S_OFF_START,
        S_OFF_WAIT,
        S_FINISH
    } state_t;

    function automatic logic [2:0] idx2code(input cidx_t i);
        logic [2:0] c;
        c = C_OFF;
        unique case (i)
            2'd0: c = GREEN;
            2'd1: c = RED;
            2'd2: c = BLUE;
            2'd3: c = YELLOW;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/genius_lfsr16.sv
// Free-running 16-bit Galois LFSR, advances every clock.
// Ports: clk, rst (sync, active-high, loads SEED), value (state out).
module genius_lfsr16
    import genius_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= SEED;
        end else begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_MASK : 16'h0000);
        end
    end

endmodule

// File: rtl/genius_seq_player.sv
// Genius colour sequence store and playback sequencer.
// Inputs: CLK, RESET (sync), PLAY/EXTEND/CLEAR requests, END_1/END_2 timer
// expiries, RD_IDX read index. Outputs: START_1/START_2 timer starts, COLOR
// lamp code, RD_COLOR read data, LEN, BUSY, DONE, FULL.
// Optional: define GENIUS_NO_REPEAT_EN to avoid identical consecutive colours.
module genius_seq_player
    import genius_pkg::*;
#(
    parameter int          MAX_LEN   = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       PLAY,
    input  logic                       EXTEND,
    input  logic                       CLEAR,
    input  logic                       END_1,
    input  logic                       END_2,
    input  logic [$clog2(MAX_LEN)-1:0] RD_IDX,
    output logic                       START_1,
    output logic                       START_2,
    output logic [2:0]                 COLOR,
    output logic [2:0]                 RD_COLOR,
    output logic [$clog2(MAX_LEN):0]   LEN,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       FULL
);

    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = IW + 1;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   idx;
    logic [LW-1:0]   len;
    cidx_t           seq [MAX_LEN];
    logic [15:0]     lfsr;
    logic            lfsr_unused;
    logic            do_clr;
    logic            do_app;
    logic            idx_clr;
    logic            idx_inc;
    logic            last;
    cidx_t           app_val;
    logic [2:0]      cur_code;

    genius_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (CLK),
        .rst   (RESET),
        .value (lfsr)
    );

    // only the two low bits pick a colour
    assign lfsr_unused = ^lfsr[15:2];

`ifdef GENIUS_NO_REPEAT_EN
    logic [IW-1:0] prev_i;
    assign prev_i = len[IW-1:0] - IW'(1);
    // bump a repeated colour to the next index so neighbours always differ
    assign app_val = (len != '0 && lfsr[1:0] == seq[prev_i])
                   ? lfsr[1:0] + 2'd1 : lfsr[1:0];
`else
    assign app_val = lfsr[1:0];
`endif

    assign FULL     = (len == LW'(MAX_LEN));
    assign LEN      = len;
    assign last     = ({1'b0, idx} == len - LW'(1));
    assign cur_code = idx2code(seq[idx]);
    assign RD_COLOR = ({1'b0, RD_IDX} < len) ? idx2code(seq[RD_IDX]) : C_OFF;

    always_comb begin
        state_nx = state;
        do_clr   = 1'b0;
        do_app   = 1'b0;
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
        START_1  = 1'b0;
        START_2  = 1'b0;
        DONE     = 1'b0;
        COLOR    = C_OFF;
        BUSY     = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (PLAY) begin
                    if (len != '0) begin
                        idx_clr  = 1'b1;
                        state_nx = S_ON_START;
                    end else begin
                        state_nx = S_FINISH;
                    end
                end else if (EXTEND && !FULL) begin
                    do_app = 1'b1;
                end
            end
            S_ON_START: begin
                START_1  = 1'b1;
                COLOR    = cur_code;
                state_nx = S_ON_WAIT;
            end
            S_ON_WAIT: begin
                COLOR = cur_code;
                if (END_1) state_nx = S_OFF_START;
            end
            S_OFF_START: begin
                START_2  = 1'b1;
                state_nx = S_OFF_WAIT;
            end
            S_OFF_WAIT: begin
                if (END_2) begin
                    if (last) begin
                        state_nx = S_FINISH;
                    end else begin
                        idx_inc  = 1'b1;
                        state_nx = S_ON_START;
                    end
                end
            end
            S_FINISH: begin
                DONE     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // CLEAR wins over everything, in any state
        if (CLEAR) begin
            state_nx = S_IDLE;
            do_clr   = 1'b1;
            do_app   = 1'b0;
            idx_clr  = 1'b0;
            idx_inc  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
            idx   <= '0;
            len   <= '0;
        end else begin
            state <= state_nx;
            if (do_clr) len <= '0;
            else if (do_app) len <= len + LW'(1);
            if (idx_clr) idx <= '0;
            else if (idx_inc) idx <= idx + IW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && do_app) seq[len[IW-1:0]] <= app_val;
    end

endmodule

// File: tb/tb_genius_seq_player.sv
// Self-checking bench for genius_seq_player: scoreboard of expected
// START_1/START_2/DONE events plus direct checks of LEN/RD_COLOR/BUSY.
module tb_genius_seq_player;

    localparam int MAX_LEN = 32;
    localparam int IW      = 5;
    localparam int K_ON    = 0;
    localparam int K_OFF   = 1;
    localparam int K_DONE  = 2;

    logic          CLK = 1'b0;
    logic          RESET, PLAY, EXTEND, CLEAR, END_1, END_2;
    logic [IW-1:0] RD_IDX;
    logic          START_1, START_2, BUSY, DONE, FULL;
    logic [2:0]    COLOR, RD_COLOR;
    logic [IW:0]   LEN;

    genius_seq_player #(.MAX_LEN(MAX_LEN), .LFSR_SEED(16'hACE1)) dut (
        .CLK(CLK), .RESET(RESET), .PLAY(PLAY), .EXTEND(EXTEND),
        .CLEAR(CLEAR), .END_1(END_1), .END_2(END_2), .RD_IDX(RD_IDX),
        .START_1(START_1), .START_2(START_2), .COLOR(COLOR),
        .RD_COLOR(RD_COLOR), .LEN(LEN), .BUSY(BUSY), .DONE(DONE),
        .FULL(FULL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         kind;
        logic [2:0] color;
        bit         lat_chk;
    } ev_t;

    ev_t        q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         end2_cyc = -100;
    int         s1n = 0;
    int         s2n = 0;
    int         t1 = 0;
    int         t2 = 0;
    logic [15:0] m_lfsr;
    logic [1:0] mseq [MAX_LEN];
    int         mlen = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        if (RESET) m_lfsr <= 16'hACE1;
        else m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0);
    end

    function automatic logic [2:0] code(input logic [1:0] i);
        logic [2:0] c;
        case (i)
            2'd0: c = 3'd2;
            2'd1: c = 3'd3;
            2'd2: c = 3'd4;
            default: c = 3'd6;
        endcase
        return c;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [2:0] c, input bit l);
        ev_t e;
        e.kind = k;
        e.color = c;
        e.lat_chk = l;
        q.push_back(e);
    endtask

    task automatic take(input int k, input logic [2:0] c);
        ev_t e;
        n_vec++;
        if (q.size() == 0) begin
            n_bad++;
            $display("FAIL mon_unexpected: got kind %0d color %0d, none expected",
                     k, c);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.color !== c ||
                (k == K_DONE && e.lat_chk && (cyc - end2_cyc) != 1)) begin
                n_bad++;
                $display("FAIL mon_event: got kind %0d color %0d lat %0d, expected kind %0d color %0d",
                         k, c, cyc - end2_cyc, e.kind, e.color);
            end
        end
    endtask

    // monitor
    always @(negedge CLK) begin
        if (RESET === 1'b0) begin
            if (START_1) begin s1n++; take(K_ON, COLOR); end
            if (START_2) begin s2n++; take(K_OFF, COLOR); end
            if (DONE) take(K_DONE, COLOR);
        end
    end

    // timer responders: END_x four cycles after START_x
    initial begin
        END_1 = 1'b0;
        END_2 = 1'b0;
        forever begin
            @(negedge CLK);
            END_1 = 1'b0;
            END_2 = 1'b0;
            if (t1 > 0) begin
                t1--;
                if (t1 == 0) END_1 = 1'b1;
            end
            if (t2 > 0) begin
                t2--;
                if (t2 == 0) begin
                    END_2 = 1'b1;
                    end2_cyc = cyc;
                end
            end
            if (START_1 === 1'b1) t1 = 4;
            if (START_2 === 1'b1) t2 = 4;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic extend();
        logic [1:0] v;
        if (mlen < MAX_LEN) begin
            v = m_lfsr[1:0];
`ifdef GENIUS_NO_REPEAT_EN
            if (mlen > 0 && v == mseq[mlen-1]) v = v + 2'd1;
`endif
            mseq[mlen] = v;
            mlen++;
        end
        EXTEND = 1'b1;
        @(negedge CLK);
        EXTEND = 1'b0;
    endtask

    task automatic do_clear();
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        mlen = 0;
    endtask

    task automatic check_store(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            RD_IDX = IW'(i);
            #1;
            chk(nm, RD_COLOR, (i < mlen) ? code(mseq[i]) : 3'd0);
        end
    endtask

    task automatic play_expect();
        for (int i = 0; i < mlen; i++) begin
            push(K_ON, code(mseq[i]), 1'b0);
            push(K_OFF, 3'd0, 1'b0);
        end
        push(K_DONE, 3'd0, mlen > 0);
        PLAY = 1'b1;
        @(negedge CLK);
        PLAY = 1'b0;
    endtask

    initial begin
        int n;
        int nb;
        bit got;
        RESET = 1'b1; PLAY = 1'b0; EXTEND = 1'b0; CLEAR = 1'b0;
        RD_IDX = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        // reset state
        chk("rst_len", LEN, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_color", COLOR, 0);
        chk("rst_start", {START_1, START_2, DONE}, 0);
        chk("rst_full", FULL, 0);

        // 1: three appends from the seed
        repeat (3) extend();
        chk("t1_len", LEN, 3);
        RD_IDX = '0;
        #1;
        chk("t1_first_red", RD_COLOR, 3);
        check_store("t1_rd", 4);

        // 2: playback of three, busy-time PLAY/EXTEND ignored
        s1n = 0; s2n = 0;
        play_expect();
        @(negedge CLK);
        PLAY = 1'b1; EXTEND = 1'b1;
        @(negedge CLK);
        PLAY = 1'b0; EXTEND = 1'b0;
        got = 0;
        for (int k = 0; k < 200; k++) begin
            if (DONE) begin got = 1; break; end
            @(negedge CLK);
        end
        chk("t2_done_seen", got, 1);
        @(negedge CLK);
        chk("t2_busy_after", BUSY, 0);
        chk("t2_len_kept", LEN, 3);
        chk("t2_s1", s1n, 3);
        chk("t2_s2", s2n, 3);
        chk("t2_q_empty", q.size(), 0);
        check_store("t2_rd", 4);

        // 3: PLAY with empty sequence
        repeat (6) @(negedge CLK);
        do_clear();
        chk("t3_len", LEN, 0);
        s1n = 0;
        play_expect();
        chk("t3_done", DONE, 1);
        nb = 0;
        for (int k = 0; k < 4; k++) begin
            if (BUSY) nb++;
            @(negedge CLK);
        end
        chk("t3_busy_cycles", nb, 1);
        chk("t3_no_start", s1n, 0);
        chk("t3_q_empty", q.size(), 0);

        // 5: CLEAR during second ON_WAIT
        repeat (3) extend();
        push(K_ON, code(mseq[0]), 1'b0);
        push(K_OFF, 3'd0, 1'b0);
        push(K_ON, code(mseq[1]), 1'b0);
        PLAY = 1'b1;
        @(negedge CLK);
        PLAY = 1'b0;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            if (START_1) n++;
            if (n == 2) break;
            @(negedge CLK);
        end
        chk("t5_reach", n, 2);
        @(negedge CLK);
        chk("t5_on_color", COLOR, code(mseq[1]));
        do_clear();
        chk("t5_busy", BUSY, 0);
        chk("t5_color", COLOR, 0);
        chk("t5_len", LEN, 0);
        repeat (12) @(negedge CLK);
        chk("t5_q_empty", q.size(), 0);
        chk("t5_idle", BUSY, 0);

        // 4: fill to MAX_LEN, one extra append ignored
        repeat (31) extend();
        chk("t4_len31", LEN, 31);
        chk("t4_notfull", FULL, 0);
        extend();
        chk("t4_len32", LEN, 32);
        chk("t4_full", FULL, 1);
        extend();
        chk("t4_len_sat", LEN, 32);
        chk("t4_full2", FULL, 1);
        check_store("t4_rd", 32);

        // 6: append when LFSR repeats the previous index
        do_clear();
        extend();
        got = 0;
        for (int k = 0; k < 64; k++) begin
            if (m_lfsr[1:0] == mseq[0]) begin got = 1; break; end
            @(negedge CLK);
        end
        chk("t6_match", got, 1);
        extend();
        chk("t6_len", LEN, 2);
        check_store("t6_rd", 3);

        chk("end_q_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
